// File: rtl/buffer_pkg.sv
// Shared defaults for the stream FIFO slice: word width, depth,
// almost-full threshold and statistics counter width.
package buffer_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_AFULL_LEVEL = 12;
    localparam int STALL_WIDTH     = 16;

    localparam logic [STALL_WIDTH-1:0] STALL_MAX = '1;

endpackage

// File: rtl/buffer_ram.sv
// Storage array for stream_fifo: one synchronous write port and one
// combinational read port. Contents are never reset.
module buffer_ram
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Ack-handshake stream FIFO with registered fall-through head word.
// Optional statistics (stall_count, peak_level) under STREAM_FIFO_STATS_EN.
module stream_fifo
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AFULL_LEVEL = DEF_AFULL_LEVEL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_in_valid,
    output logic                       data_in_ack,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_read,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic [STALL_WIDTH-1:0]     stall_count,
    output logic [$clog2(DEPTH):0]     peak_level
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LW         = ADDR_WIDTH + 1;

    localparam logic [LW-1:0] FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL = LW'(AFULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr_n;
    logic [LW-1:0]         level_n;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] head_n;
    logic                  push;
    logic                  pop;
    logic                  bypass;

    assign push     = data_in_valid && (level != FULL) && !data_in_ack;
    assign pop      = data_out_read && data_out_valid;
    assign rd_ptr_n = rd_ptr + ADDR_WIDTH'(pop);

    // New word becomes the head when nothing survives ahead of it
    assign bypass = push && (level == LW'(pop));

    buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr_n),
        .rdata (rdata)
    );

    always_comb begin
        level_n = level;
        if (push && !pop)      level_n = level + LW'(1);
        else if (pop && !push) level_n = level - LW'(1);
    end

    always_comb begin
        head_n = rdata;
        if (level_n == '0) head_n = '0;
        else if (bypass)   head_n = data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            almost_full    <= 1'b0;
            data_in_ack    <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            rd_ptr         <= rd_ptr_n;
            level          <= level_n;
            almost_full    <= (level_n >= AFULL);
            data_in_ack    <= push;
            data_out       <= head_n;
            data_out_valid <= (level_n != '0);
        end
    end

`ifdef STREAM_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            peak_level  <= '0;
        end else begin
            if (data_in_valid && !data_in_ack && level == FULL &&
                stall_count != STALL_MAX)
                stall_count <= stall_count + STALL_WIDTH'(1);
            if (level_n > peak_level) peak_level <= level_n;
        end
    end
`else
    assign stall_count = '0;
    assign peak_level  = '0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo (default parameters).
// Statistics expectations follow STREAM_FIFO_STATS_EN.
module tb_stream_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ack;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_read = 1'b0;
    logic [4:0]  level;
    logic        almost_full;
    logic [15:0] stall_count;
    logic [4:0]  peak_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] sb[$];
    bit          m_ack = 0;
    int          m_stall = 0;
    int          m_peak = 0;

    stream_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ack    (data_in_ack),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_read  (data_out_read),
        .level          (level),
        .almost_full    (almost_full),
        .stall_count    (stall_count),
        .peak_level     (peak_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] head;
        head = '0;
        if (sb.size() != 0) head = sb[0];
        check("data_out", data_out, head);
        check("valid", 32'(data_out_valid), 32'(sb.size() != 0));
        check("level", 32'(level), 32'(sb.size()));
        check("afull", 32'(almost_full), 32'(sb.size() >= 12));
        check("ack", 32'(data_in_ack), 32'(m_ack));
`ifdef STREAM_FIFO_STATS_EN
        check("stall", 32'(stall_count), 32'(m_stall));
        check("peak", 32'(peak_level), 32'(m_peak));
`else
        check("stall", 32'(stall_count), 32'h0);
        check("peak", 32'(peak_level), 32'h0);
`endif
    endtask

    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic r, output bit pushed);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        check_outputs();
        data_in_valid = v;
        data_in       = d;
        data_out_read = r;
        do_push = v && sb.size() < 16 && !m_ack;
        do_pop  = r && sb.size() != 0;
        if (v && !m_ack && sb.size() == 16 && m_stall != 16'hFFFF)
            m_stall++;
        @(posedge clk);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(d);
        m_ack = do_push;
        if (sb.size() > m_peak) m_peak = sb.size();
        pushed = do_push;
    endtask

    task automatic idle(input int n);
        bit p;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, p);
    endtask

    task automatic push_word(input logic [31:0] w);
        bit p;
        p = 0;
        for (int t = 0; t < 4 && !p; t++) cycle(1'b1, w, 1'b0, p);
        check("push_done", 32'(p), 32'h1);
    endtask

    task automatic drain();
        bit p;
        for (int t = 0; t < 40 && sb.size() != 0; t++)
            cycle(1'b0, '0, 1'b1, p);
        check("drained", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        bit p;
        #3;
        check("rst_dout", data_out, 32'h0);
        check("rst_valid", 32'(data_out_valid), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_ack", 32'(data_in_ack), 32'h0);
        #20;
        rst = 1'b1;
        idle(2);

        // single push into empty FIFO: fall-through in parallel with ack
        cycle(1'b1, 32'hA5A5A5A5, 1'b0, p);
        #1;
        check("ft_data", data_out, 32'hA5A5A5A5);
        check("ft_valid", 32'(data_out_valid), 32'h1);
        check("ft_ack", 32'(data_in_ack), 32'h1);
        check("ft_level", 32'(level), 32'h1);
        idle(1);
        drain();

        // fill to full, then hold a 17th word
        for (int w = 1; w <= 16; w++) push_word(32'(w));
        idle(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'd17, 1'b0, p);
        check("full_level", 32'(level), 32'd16);
        check("full_afull", 32'(almost_full), 32'h1);
        data_in_valid = 1'b0;

        // read all 16 back in order
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, p);
        idle(1);
        check("empty_valid", 32'(data_out_valid), 32'h0);
        check("empty_data", data_out, 32'h0);
        check("empty_level", 32'(level), 32'h0);

        // level 5 with simultaneous push/pop across pointer wrap
        for (int w = 0; w < 5; w++) push_word(32'h100 + 32'(w));
        idle(1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'h200 + 32'(i), 1'b1, p);
            check("pp_push", 32'(p), 32'h1);
            cycle(1'b0, '0, 1'b0, p);
        end
        check("pp_level", 32'(level), 32'd5);
        drain();

        // asynchronous reset between edges with level 7
        for (int w = 0; w < 7; w++) push_word(32'h300 + 32'(w));
        idle(1);
        check("pre_rst_level", 32'(level), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'h0);
        check("arst_valid", 32'(data_out_valid), 32'h0);
        check("arst_dout", data_out, 32'h0);
        check("arst_afull", 32'(almost_full), 32'h0);
        check("arst_stall", 32'(stall_count), 32'h0);
        check("arst_peak", 32'(peak_level), 32'h0);
        sb.delete();
        m_ack = 0;
        m_stall = 0;
        m_peak = 0;
        #1;
        rst = 1'b1;
        idle(1);
        push_word(32'h0BAD_CAFE);
        #1;
        check("post_rst_level", 32'(level), 32'h1);
        idle(1);
        drain();
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
